uart_fifo_core: RTL and testbench

Byte-wide UART transmitter/receiver that sits directly behind the J1 I/O bus UART slot (io_addr bit 12 data, bit 13 status). It consumes the bus write/read strobes and outgoing byte, and produces the busy, valid and received-byte signals the bus read mux returns to the CPU. It also drives and samples the serial pins, and optionally buffers received bytes in a small FIFO.

---
 rtl/uart_fifo_core.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - 8N1 UART TX/RX for the J1 I/O slot; define UART_RX_FIFO_EN for a receive FIFO
module uart_fifo_core #(
    parameter int CLKFREQ       = 12000000,
    parameter int BAUD          = 115200,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] tx_data,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       valid,
    output logic       overrun,
    input  logic       rx,
    output logic       tx
);
    localparam int DIV = (CLKFREQ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_C  = CW'(DIV);
    localparam logic [CW-1:0] HALF_C = CW'(DIV / 2);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    if (DIV < 4 || RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_cfg_check
        $error("uart_fifo_core: unsupported DIV or RX_FIFO_DEPTH");
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Counters hold the cycles remaining in the current bit; a value of one marks the bit end.
    tx_state_t       tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_bit, tx_bit_n;
    logic [7:0]      tx_shift, tx_shift_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        case (tx_state)
            TX_IDLE: begin
                if (wr) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = DIV_C;
                    tx_shift_n = tx_data;
                end
            end
            TX_START: begin
                if (tx_cnt == ONE_C) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = DIV_C;
                    tx_bit_n   = 3'd0;
                end else begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == ONE_C) begin
                    tx_cnt_n   = DIV_C;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                    else                tx_bit_n   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == ONE_C) tx_state_n = TX_IDLE;
                else                 tx_cnt_n   = tx_cnt - 1'b1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign busy = (tx_state != TX_IDLE);
    assign tx   = (tx_state == TX_START) ? 1'b0 :
                  (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    // rx_prev low after a framing error keeps the receiver disarmed until the line idles high.
    logic [1:0]      rx_sync;
    logic            rx_s, rx_prev, rx_done, rx_done_n;
    rx_state_t       rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_bit, rx_bit_n;
    logic [7:0]      rx_shift, rx_shift_n;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_prev  <= rx_s;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_done  <= rx_done_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = HALF_C;
                end
            end
            RX_START: begin
                if (rx_cnt == ONE_C) begin
                    if (rx_s) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = DIV_C;
                        rx_bit_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == ONE_C) begin
                    rx_cnt_n   = DIV_C;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == ONE_C) begin
                    rx_state_n = RX_IDLE;
                    rx_done_n  = rx_s;
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    logic pop, ovr_set;
    assign pop = rd && valid;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    logic [7:0]  mem [RX_FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign valid   = !empty;
    assign rx_data = empty ? 8'h00 : mem[rptr[AW-1:0]];
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the delivery.
    assign push    = rx_done && (!full || pop);
    assign ovr_set = rx_done && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= rx_shift;
    end
`else
    logic [7:0] hold;
    logic       hold_v;

    assign valid   = hold_v;
    assign rx_data = hold;
    assign ovr_set = rx_done && hold_v && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold   <= 8'h00;
            hold_v <= 1'b0;
        end else if (rx_done) begin
            hold   <= rx_shift;
            hold_v <= 1'b1;
        end else if (pop) begin
            hold_v <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)        overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
        else if (pop)     overrun <= 1'b0;
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - scoreboard bench for uart_fifo_core (DIV=10)
module tb_uart_fifo_core;
    localparam int CLKFREQ = 1000000;
    localparam int BAUD    = 100000;
    localparam int DIV     = 10;
    localparam int DEPTH   = 4;
`ifdef UART_RX_FIFO_EN
    localparam int FILL = DEPTH;
`else
    localparam int FILL = 1;
`endif

    logic       clk = 1'b0, reset = 1'b1, wr = 1'b0, rd = 1'b0, rx = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       busy, valid, overrun, tx;

    uart_fifo_core #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .RX_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .tx_data(tx_data), .rd(rd),
        .rx_data(rx_data), .busy(busy), .valid(valid), .overrun(overrun),
        .rx(rx), .tx(tx)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_err = 0;
    logic [7:0] tx_exp[$], rx_exp[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int c = 0; c < 10 * DIV; c++) begin
            rx = fr[c / DIV];
            tick();
        end
        rx = 1'b1;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        while (valid !== 1'b1 && k < max) begin
            tick();
            k++;
        end
        chk("rx_valid_rise", 32'(valid), 1);
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (busy !== 1'b0 && k < max) begin
            tick();
            k++;
        end
        chk("tx_busy_fall", 32'(busy), 0);
    endtask

    // Serial-line decoder for tx: samples mid-bit and checks each frame against tx_exp.
    int         m_on = 0, m_cnt = 0, m_idx = 0;
    logic [7:0] m_byte;
    always @(negedge clk) begin
        if (reset) begin
            m_on = 0;
        end else if (m_on == 0) begin
            if (tx === 1'b0) begin
                m_on  = 1;
                m_cnt = DIV / 2;
                m_idx = 0;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_cnt = DIV;
                if (m_idx == 0) begin
                    chk("tx_start_bit", 32'(tx), 0);
                end else if (m_idx <= 8) begin
                    m_byte[m_idx-1] = tx;
                end else begin
                    chk("tx_stop_bit", 32'(tx), 1);
                    if (tx_exp.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL tx_unexpected_frame: actual %0h required none", m_byte);
                    end else begin
                        chk("tx_byte", 32'(m_byte), 32'(tx_exp.pop_front()));
                    end
                    m_on = 0;
                end
                m_idx++;
            end
        end
    end

    // Every accepted CPU read is checked against the receive scoreboard.
    always @(negedge clk) begin
        if (!reset && rd && valid) begin
            if (rx_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rx_unexpected_pop: actual %0h required none", rx_data);
            end else begin
                chk("rx_data_pop", 32'(rx_data), 32'(rx_exp.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         busy_cnt;
        logic [9:0] fr;

        repeat (3) tick();
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_rx_data", 32'(rx_data), 0);
        reset = 1'b0;
        tick();

        // TX 0x55 with an ignored wr of 0xFF mid-frame, then a back-to-back 0xC3.
        tx_exp.push_back(8'h55);
        tx_data = 8'h55;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (busy_cnt > 0 && !busy) break;
            if (busy) busy_cnt++;
            if (c == 50) begin
                wr = 1'b1;
                tx_data = 8'hFF;
            end else begin
                wr = 1'b0;
            end
            tick();
        end
        chk("tx_busy_cycles", busy_cnt, 100);
        tx_exp.push_back(8'hC3);
        tx_data = 8'hC3;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("tx_back_to_back_busy", 32'(busy), 1);
        chk("tx_back_to_back_start", 32'(tx), 0);
        wait_idle(150);

        // RX 0xA3, then a pop.
        rx_exp.push_back(8'hA3);
        send_rx(8'hA3, 1'b1);
        wait_valid(20);
        chk("rx_head_a3", 32'(rx_data), 32'h A3);
        pulse_rd();
        chk("rx_valid_after_rd", 32'(valid), 0);

        // Framing error, then a short glitch: neither may deliver a byte.
        send_rx(8'h3C, 1'b0);
        repeat (30) tick();
        chk("framing_no_valid", 32'(valid), 0);
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (4 * DIV) tick();
        chk("glitch_no_valid", 32'(valid), 0);
        chk("glitch_no_overrun", 32'(overrun), 0);

        // Overrun with no reads.
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) rx_exp.push_back(8'(i));
            send_rx(8'(i), 1'b1);
        end
        chk("fifo_overrun_set", 32'(overrun), 1);
        pulse_rd();
        chk("fifo_overrun_clear", 32'(overrun), 0);
        repeat (3) pulse_rd();
        chk("fifo_drained", 32'(valid), 0);
`else
        rx_exp.push_back(8'h22);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        chk("reg_overrun_set", 32'(overrun), 1);
        chk("reg_head_22", 32'(rx_data), 32'h22);
        pulse_rd();
        chk("reg_overrun_clear", 32'(overrun), 0);
        chk("reg_drained", 32'(valid), 0);
`endif

        // Store full, rd lands in the delivery cycle of 0x77 (98 cycles after the start bit begins).
        for (int i = 0; i < FILL; i++) begin
            rx_exp.push_back(8'h10 + 8'(i));
            send_rx(8'h10 + 8'(i), 1'b1);
        end
        chk("full_no_overrun", 32'(overrun), 0);
        rx_exp.push_back(8'h77);
        fork
            send_rx(8'h77, 1'b1);
            begin
                repeat (98) tick();
                rd = 1'b1;
                tick();
                rd = 1'b0;
            end
        join
        chk("simul_overrun", 32'(overrun), 0);
        for (int i = 0; i < FILL - 1; i++) begin
            chk("simul_still_valid", 32'(valid), 1);
            pulse_rd();
        end
        chk("simul_last_valid", 32'(valid), 1);
        pulse_rd();
        chk("simul_drained", 32'(valid), 0);

        // Reset with a stored byte, TX in bit 3 and RX in data bit 5.
        send_rx(8'h42, 1'b1);
        chk("stored_before_reset", 32'(valid), 1);
        fr = {1'b1, 8'h66, 1'b0};
        tx_data = 8'h99;
        for (int c = 0; c < 65; c++) begin
            rx = fr[c / DIV];
            wr = (c == 20);
            tick();
        end
        rx = 1'b1;
        wr = 1'b0;
        reset = 1'b1;
        tx_exp.delete();
        rx_exp.delete();
        tick();
        chk("midreset_tx", 32'(tx), 1);
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_valid", 32'(valid), 0);
        reset = 1'b0;
        tick();

        tx_exp.push_back(8'h5A);
        rx_exp.push_back(8'h5A);
        tx_data = 8'h5A;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        send_rx(8'h5A, 1'b1);
        wait_idle(20);
        wait_valid(20);
        chk("post_reset_head", 32'(rx_data), 32'h5A);
        pulse_rd();
        chk("post_reset_drained", 32'(valid), 0);

        repeat (20) tick();
        chk("tx_pending", 32'(tx_exp.size()), 0);
        chk("rx_pending", 32'(rx_exp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
